// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcode field
// position and default control opcodes.
package seq_pkg;

    localparam int unsigned INSTR_W = 17;
    localparam int unsigned OPC_MSB = 16;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_JMP_DEF = 5'b11110;
    localparam logic [OPC_W-1:0] OP_HLT_DEF = 5'b11111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StHalt
    } seq_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with next-PC priority: restart, then halt/jump/branch/increment on a
// handshake.
module pc_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic            advance,
    input  logic            is_hlt,
    input  logic            is_jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (restart) begin
            pc_d = RESET_PC;
        end else if (advance) begin
            if (is_hlt) begin
                pc_d = pc_q;
            end else if (is_jmp) begin
                pc_d = jmp_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                // Wraps from all-ones to zero by design.
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: fetches from a synchronous ROM, hands each word to the control
// unit under valid/ready and resolves jump, branch and halt before the next fetch.
module instr_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = seq_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      OP_JMP   = seq_pkg::OP_JMP_DEF,
    parameter logic [4:0]      OP_HLT   = seq_pkg::OP_HLT_DEF,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               cu_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    import seq_pkg::*;

    seq_state_e         state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   retired_q;

    logic       handshake;
    logic       restart;
    logic [4:0] opcode;
    logic       is_hlt;
    logic       is_jmp;

    assign handshake = (state_q == StIssue) && cu_ready;
    assign restart   = (state_q == StHalt) && start;
    assign opcode    = opcode_of(instr_q);
    assign is_hlt    = (opcode == OP_HLT);
    assign is_jmp    = (opcode == OP_JMP);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: state_d = StLoad;
            StLoad:  state_d = StIssue;
            StIssue: if (cu_ready) state_d = is_hlt ? StHalt : StFetch;
            StHalt:  if (start) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured once per instruction so it stays stable for the whole ISSUE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
        end else if (state_q == StLoad) begin
            instr_q <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (restart) begin
            retired_q <= '0;
        end else if (handshake && (retired_q != '1)) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart       (restart),
        .advance       (handshake),
        .is_hlt        (is_hlt),
        .is_jmp        (is_jmp),
        .jmp_target    (instr_q[PC_W-1:0]),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = (state_q == StIssue);
    assign busy        = (state_q == StFetch) || (state_q == StLoad) || (state_q == StIssue);
    assign halted      = (state_q == StHalt);
    assign retired     = retired_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/issue controller placed in front of the control unit `cu`. It owns the program counter and fetches 17-bit instructions from a synchronous instruction ROM. Each instruction is presented to `cu` under a valid/ready handshake, and the sequencer resolves jump, branch and halt before fetching the next word. The sequencer replaces bench-driven `instruction` stimulus with a self-running instruction stream.

## Interface

**Parameters** (name, default, meaning)
- `PC_W`, 8: program-counter and ROM address width.
- `INSTR_W`, 17: instruction width. Fixed to match `cu`.
- `RESET_PC`, 0: PC value loaded at reset and on restart.
- `OP_JMP`, 5'b11110: opcode of an unconditional jump. Target is `instr[PC_W-1:0]`.
- `OP_HLT`, 5'b11111: opcode of halt.
- `CNT_W`, 16: width of the retired-instruction counter.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse. Begins execution from IDLE or HALT.
- `imem_addr`, out, PC_W: ROM address. The ROM registers it; data is returned on the next cycle.
- `imem_rdata`, in, INSTR_W: ROM data, valid one cycle after `imem_addr`.
- `instr`, out, INSTR_W: instruction presented to `cu`.
- `instr_valid`, out, 1: `instr` is valid and held stable.
- `cu_ready`, in, 1: `cu` accepts or retires `instr` in this cycle.
- `branch_taken`, in, 1: `cu` branch outcome, sampled only in the handshake cycle.
- `branch_target`, in, PC_W: branch destination, sampled with `branch_taken`.
- `pc`, out, PC_W: address of the current or next instruction.
- `busy`, out, 1: high in FETCH, LOAD and ISSUE.
- `halted`, out, 1: high in HALT.
- `retired`, out, CNT_W: count of completed handshakes. Saturates at all-ones.

## Operation

**Opcode:** `instr[16:12]`.

**States and transitions**
- **IDLE**
  - Outputs idle.
  - `start` → FETCH.
- **FETCH**
  - `imem_addr` = `pc`.
  - Unconditionally → LOAD.
- **LOAD**
  - `instr` ← `imem_rdata` (registered).
  - → ISSUE.
- **ISSUE**
  - `instr_valid` = 1; `instr` is held stable.
  - Wait while `cu_ready` = 0.
  - On `instr_valid && cu_ready` (the handshake):
    - `retired` increments.
    - Next PC, in priority order:
      1. Opcode `OP_HLT`: `pc` unchanged, go to HALT.
      2. Opcode `OP_JMP`: `pc` ← `instr[PC_W-1:0]`.
      3. `branch_taken`: `pc` ← `branch_target`.
      4. Otherwise: `pc` ← `pc + 1`, modulo 2^PC_W. The PC wraps from all-ones to 0 with no error.
    - Go to FETCH, except after `OP_HLT`.
- **HALT**
  - `halted` = 1; `pc` points at the HLT instruction.
  - `start` → `pc` ← `RESET_PC`, `retired` ← 0, → FETCH.

**Input handling**
- `start` is ignored in FETCH, LOAD and ISSUE.
- `cu_ready` is ignored outside ISSUE.
- `branch_taken` is ignored when the opcode is `OP_JMP` or `OP_HLT`.
- `imem_addr` is driven with `pc` in every state. The ROM read is only meaningful in FETCH.

## Timing

**Reset values** (applied immediately when `rst_n` = 0, independent of `clk`)
- State = IDLE.
- `pc` = `RESET_PC`; `imem_addr` = `RESET_PC`.
- `instr` = 0; `instr_valid` = 0.
- `busy` = 0; `halted` = 0; `retired` = 0.

**Reset mid-operation**
- Asserting `rst_n` in any state aborts the instruction in flight.
- No handshake is counted for the aborted instruction.

**Latency**
- `start` sampled at edge N: FETCH in cycle N+1, LOAD in N+2, `instr_valid` high from N+3.
- Minimum issue interval is 3 cycles per instruction (FETCH, LOAD, ISSUE) when `cu_ready` is tied high.
- A handshake at edge M updates `pc` at edge M. `instr_valid` goes low in cycle M+1 (FETCH).

**Back-pressure**
- Each cycle of `cu_ready` = 0 in ISSUE adds exactly one cycle.
- `instr` must not change while `instr_valid` = 1.

**Counter**
- `retired` saturates at 2^CNT_W − 1 and never wraps.

## Structure

**Package `seq_pkg`**
- State enum: IDLE, FETCH, LOAD, ISSUE, HALT.
- Opcode field constants: bits 16:12.
- Default `OP_JMP` and `OP_HLT` values.
- `INSTR_W` = 17.

**Sub-module `pc_unit`**
- Contains the PC register and the next-PC priority mux (halt, jump, branch, increment, restart).
- Has its own async active-low reset to `RESET_PC`.
- The top level keeps the FSM, the instruction register and the counter.

## Test plan

1. **Reset and idle.** Assert `rst_n` = 0 mid-ISSUE → all outputs take their reset values immediately; with no `start`, the block stays IDLE.
2. **Straight-line run.** ROM[0..2] = non-control words, ROM[3] = `5'b11111`, `cu_ready` = 1 → `instr_valid` pulses at cycles 3, 6, 9 and 12 after `start`; `halted` = 1, `pc` = 3, `retired` = 4.
3. **Back-pressure.** Hold `cu_ready` = 0 for 5 cycles in ISSUE → `instr` stays stable, `instr_valid` = 1 throughout; `pc` advances by 1 only after the handshake.
4. **Jump and branch.**
   - ROM[0] = `OP_JMP` with target `8'h40` → next fetch address is `8'h40`.
   - At 0x40, drive `branch_taken` = 1, `branch_target` = `8'h10` in the handshake cycle → next fetch address is `8'h10`.
   - `branch_taken` asserted while not in a handshake → no effect.
5. **Wrap and restart.**
   - `RESET_PC` = `8'hFF`, ROM[FF] non-control → next fetch address is `8'h00`.
   - `start` in HALT → `pc` = `RESET_PC`, `retired` = 0, `instr_valid` high 3 cycles later.
